// File: rtl/merge_select_nway.sv
// N-way sorted-stream merge: a combinational min-tree picks the eligible channel with
// the smallest row index and a single output register carries the merged beat.

`ifndef DATA_WIDTH_BUFF_SO_SEG
`define DATA_WIDTH_BUFF_SO_SEG 64
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 16
`endif

module merge_select_nway #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH_BUFF_SO_SEG,
    parameter int ROW_BITS   = `BITS_ROW_IDX,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         clear,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_last,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         out_count
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int NODES = 2 * NUM_IN;

    logic [NUM_IN-1:0]     done_mask;
    logic [NUM_IN-1:0]     eligible;
    logic                  node_valid [NODES];
    logic [ROW_BITS-1:0]   node_row   [NODES];
    logic [IDX_W-1:0]      node_idx   [NODES];

    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_IN-1:0]     win_onehot;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_last;
    logic                  others_done;
    logic                  load;
    logic                  accept;

    assign eligible = in_valid & ~done_mask;

    // Heap-ordered tree: leaves at NUM_IN+i, node n merges 2n (lower channels) and 2n+1.
    // Using <= on the left child makes ties go to the lower channel number.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            node_valid[n] = 1'b0;
            node_row[n]   = '0;
            node_idx[n]   = '0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            node_valid[NUM_IN+i] = eligible[i];
            node_row[NUM_IN+i]   = in_data[i*DATA_WIDTH + DATA_WIDTH - 1 -: ROW_BITS];
            node_idx[NUM_IN+i]   = IDX_W'(i);
        end
        for (int n = NUM_IN - 1; n >= 1; n--) begin
            if (node_valid[2*n] &&
                (!node_valid[2*n+1] || (node_row[2*n] <= node_row[2*n+1]))) begin
                node_valid[n] = node_valid[2*n];
                node_row[n]   = node_row[2*n];
                node_idx[n]   = node_idx[2*n];
            end else begin
                node_valid[n] = node_valid[2*n+1];
                node_row[n]   = node_row[2*n+1];
                node_idx[n]   = node_idx[2*n+1];
            end
        end
    end

    assign win_valid   = node_valid[1];
    assign win_idx     = node_idx[1];
    assign win_onehot  = NUM_IN'(1) << win_idx;
    assign win_data    = in_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign win_last    = in_last[win_idx];
    assign others_done = &(done_mask | win_onehot);

    // Handshake: a beat moves on any edge where valid and ready are both high. The output
    // register refills whenever it is empty or being drained, so in_ready never waits on itself.
    assign load     = win_valid && (!out_valid || out_ready);
    assign accept   = out_valid && out_ready;
    assign in_ready = (load && rst_b) ? win_onehot : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_last  <= win_last && others_done;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // clear only touches completion tracking; a beat sitting in the output register survives it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            done_mask <= '0;
            done      <= 1'b0;
            out_count <= '0;
        end else if (clear) begin
            done_mask <= '0;
            done      <= 1'b0;
            out_count <= '0;
        end else begin
            if (load && win_last) begin
                done_mask <= done_mask | win_onehot;
            end
            if (accept && out_last) begin
                done <= 1'b1;
            end
            if (accept) begin
                out_count <= out_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_merge_select_nway.sv
// Bench for merge_select_nway: a 4-way instance for directed scenarios and a 16-way
// instance for a wide merge, each with a queue-fed driver and a scoreboard monitor.

module tb_merge_select_nway;

    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_b;
    logic clear;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4*DW-1:0]  in_data4;
    logic [3:0]       in_valid4, in_last4, in_ready4;
    logic [DW-1:0]    out_data4;
    logic             out_valid4, out_ready4, out_last4, done4;
    logic [CW-1:0]    out_count4;

    logic [16*DW-1:0] in_data16;
    logic [15:0]      in_valid16, in_last16, in_ready16;
    logic [DW-1:0]    out_data16;
    logic             out_valid16, out_ready16, out_last16, done16;
    logic [CW-1:0]    out_count16;

    merge_select_nway #(.NUM_IN(4), .DATA_WIDTH(DW), .ROW_BITS(8), .CNT_WIDTH(CW)) dut4 (
        .clk(clk), .rst_b(rst_b), .clear(clear),
        .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4), .in_ready(in_ready4),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_last(out_last4), .done(done4), .out_count(out_count4)
    );

    merge_select_nway #(.NUM_IN(16), .DATA_WIDTH(DW), .ROW_BITS(8), .CNT_WIDTH(CW)) dut16 (
        .clk(clk), .rst_b(rst_b), .clear(clear),
        .in_data(in_data16), .in_valid(in_valid16), .in_last(in_last16), .in_ready(in_ready16),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_last(out_last16), .done(done16), .out_count(out_count16)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Per-channel stimulus memories; entry = {last, row[7:0], tag[7:0]}.
    logic [16:0] mem4 [4][16];
    int          wr4 [4];
    int          rd4 [4];
    logic [16:0] mem16 [16][4];
    int          wr16 [16];
    int          rd16 [16];
    logic        oready_req;
    logic [3:0]  rdy_log [$];

    logic [16:0] exp4_q  [$];
    logic [16:0] exp16_q [$];

    task automatic flush4();
        for (int i = 0; i < 4; i++) begin
            wr4[i] = 0;
            rd4[i] = 0;
        end
    endtask

    task automatic flush16();
        for (int i = 0; i < 16; i++) begin
            wr16[i] = 0;
            rd16[i] = 0;
        end
    endtask

    task automatic push4(input int ch, input logic [7:0] row, input logic last);
        mem4[ch][wr4[ch]] = {last, row, 8'(ch)};
        wr4[ch]++;
    endtask

    task automatic push16(input int ch, input logic [7:0] row, input logic last);
        mem16[ch][wr16[ch]] = {last, row, 8'(ch)};
        wr16[ch]++;
    endtask

    task automatic exp4(input logic [7:0] row, input int tag, input logic last);
        exp4_q.push_back({last, row, 8'(tag)});
    endtask

    task automatic exp16(input logic [7:0] row, input int tag, input logic last);
        exp16_q.push_back({last, row, 8'(tag)});
    endtask

    // Drivers: inputs change on the falling edge, grants are sampled just before the rising edge.
    initial begin
        in_valid4 = '0; in_last4 = '0; in_data4 = '0; out_ready4 = 1'b0;
        forever begin
            @(negedge clk);
            out_ready4 = oready_req;
            for (int i = 0; i < 4; i++) begin
                if (rd4[i] < wr4[i]) begin
                    in_valid4[i] = 1'b1;
                    {in_last4[i], in_data4[i*DW +: DW]} = mem4[i][rd4[i]];
                end else begin
                    in_valid4[i] = 1'b0;
                    in_last4[i]  = 1'b0;
                    in_data4[i*DW +: DW] = '0;
                end
            end
            #4;
            if ((in_valid4 & in_ready4) != 4'b0000) rdy_log.push_back(in_ready4);
            for (int i = 0; i < 4; i++) begin
                if (in_valid4[i] && in_ready4[i]) rd4[i]++;
            end
        end
    end

    initial begin
        in_valid16 = '0; in_last16 = '0; in_data16 = '0; out_ready16 = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                if (rd16[i] < wr16[i]) begin
                    in_valid16[i] = 1'b1;
                    {in_last16[i], in_data16[i*DW +: DW]} = mem16[i][rd16[i]];
                end else begin
                    in_valid16[i] = 1'b0;
                    in_last16[i]  = 1'b0;
                    in_data16[i*DW +: DW] = '0;
                end
            end
            #4;
            for (int i = 0; i < 16; i++) begin
                if (in_valid16[i] && in_ready16[i]) rd16[i]++;
            end
        end
    end

    // Monitors: pop and compare on every accepted output beat.
    int acc4_n = 0, first_acc4 = 0, last_acc4 = 0;
    int acc16_n = 0, mono_bad = 0;
    logic [7:0] prev_row16 = 8'd0;

    initial forever begin
        @(negedge clk);
        #4;
        if (out_valid4 && out_ready4) begin
            if (acc4_n == 0) first_acc4 = cyc;
            acc4_n++;
            last_acc4 = cyc;
            if (exp4_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL beat4_unexpected: got %0h, want no beat", {out_last4, out_data4});
            end else begin
                check("beat4", {15'b0, out_last4, out_data4}, {15'b0, exp4_q.pop_front()});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #4;
        if (out_valid16 && out_ready16) begin
            acc16_n++;
            if (out_data16[15:8] < prev_row16) mono_bad++;
            prev_row16 = out_data16[15:8];
            if (exp16_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL beat16_unexpected: got %0h, want no beat", {out_last16, out_data16});
            end else begin
                check("beat16", {15'b0, out_last16, out_data16}, {15'b0, exp16_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    int done_cyc;
    logic found;

    initial begin
        rst_b = 1'b0;
        clear = 1'b0;
        oready_req = 1'b1;
        flush4();
        flush16();
        push4(0, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #4;
        check("rst out_valid", out_valid4, 0);
        check("rst out_last", out_last4, 0);
        check("rst out_data", out_data4, 0);
        check("rst done", done4, 0);
        check("rst out_count", out_count4, 0);
        check("rst in_ready gated", in_ready4, 0);
        check("rst16 out_valid", out_valid16, 0);
        @(posedge clk);
        flush4();
        @(negedge clk);
        rst_b = 1'b1;

        // Basic merge of four sorted streams.
        @(posedge clk);
        flush4();
        acc4_n = 0;
        push4(0, 8'd1, 1'b0); push4(0, 8'd5, 1'b1);
        push4(1, 8'd2, 1'b0); push4(1, 8'd3, 1'b1);
        push4(2, 8'd4, 1'b1);
        push4(3, 8'd0, 1'b1);
        exp4(0, 3, 0); exp4(1, 0, 0); exp4(2, 1, 0);
        exp4(3, 1, 0); exp4(4, 2, 0); exp4(5, 0, 1);
        found = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #4;
            if (done4) begin
                found = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check("A done seen", found, 1);
        check("A done timing", done_cyc, last_acc4 + 1);
        check("A consecutive", last_acc4 - first_acc4, 5);
        check("A beats", acc4_n, 6);
        check("A out_count", out_count4, 6);
        check("A drained", exp4_q.size(), 0);

        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #4;
        check("clear done", done4, 0);
        check("clear out_count", out_count4, 0);

        // Tie on row 7 between channels 1 and 3.
        @(posedge clk);
        flush4();
        rdy_log.delete();
        acc4_n = 0;
        push4(1, 8'd7, 1'b0);
        push4(3, 8'd7, 1'b0);
        exp4(7, 1, 0); exp4(7, 3, 0);
        repeat (8) @(posedge clk);
        check("B grants", rdy_log.size(), 2);
        if (rdy_log.size() == 2) begin
            check("B first grant", rdy_log[0], 4'b0010);
            check("B second grant", rdy_log[1], 4'b1000);
        end
        check("B back-to-back", last_acc4 - first_acc4, 1);
        check("B drained", exp4_q.size(), 0);

        // Backpressure: output held for three cycles.
        @(posedge clk);
        flush4();
        rdy_log.delete();
        oready_req = 1'b0;
        push4(0, 8'd10, 1'b0); push4(0, 8'd11, 1'b0); push4(0, 8'd12, 1'b0);
        exp4(10, 0, 0); exp4(11, 0, 0); exp4(12, 0, 0);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #4;
            check("C stall valid", out_valid4, 1);
            check("C stall data", out_data4, {8'd10, 8'd0});
            check("C stall in_ready", in_ready4, 0);
        end
        @(posedge clk);
        oready_req = 1'b1;
        repeat (8) @(posedge clk);
        check("C drained", exp4_q.size(), 0);
        check("C grants", rdy_log.size(), 3);
        check("C out_count", out_count4, 5);

        // Finished channel 2 offers row 0 again but stays masked until clear.
        @(posedge clk);
        flush4();
        rdy_log.delete();
        push4(2, 8'd20, 1'b1); push4(2, 8'd0, 1'b0);
        push4(0, 8'd30, 1'b0);
        exp4(20, 2, 0); exp4(30, 0, 0);
        repeat (12) @(posedge clk);
        check("D drained", exp4_q.size(), 0);
        check("D ch2 held", rd4[2], 1);
        check("D grants", rdy_log.size(), 2);
        check("D out_count", out_count4, 7);
        exp4(0, 2, 0);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (6) @(posedge clk);
        check("D after clear drained", exp4_q.size(), 0);
        check("D ch2 released", rd4[2], 2);
        check("D after clear count", out_count4, 1);

        // Asynchronous reset with a beat parked in the output register.
        @(posedge clk);
        flush4();
        oready_req = 1'b0;
        push4(0, 8'd40, 1'b0); push4(0, 8'd41, 1'b0); push4(0, 8'd42, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("E pre-reset valid", out_valid4, 1);
        rst_b = 1'b0;
        #1;
        check("E rst out_valid", out_valid4, 0);
        check("E rst out_data", out_data4, 0);
        check("E rst out_last", out_last4, 0);
        check("E rst done", done4, 0);
        check("E rst out_count", out_count4, 0);
        check("E rst in_ready", in_ready4, 0);
        flush4();
        exp4_q.delete();
        oready_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #4;
        check("E release count", out_count4, 0);
        check("E release valid", out_valid4, 0);
        @(posedge clk);
        push4(1, 8'd50, 1'b1);
        exp4(50, 1, 0);
        repeat (6) @(posedge clk);
        check("E restart drained", exp4_q.size(), 0);
        check("E restart count", out_count4, 1);

        // Sixteen channels, two beats each, with pairwise row ties.
        @(posedge clk);
        flush16();
        for (int ch = 0; ch < 16; ch++) begin
            push16(ch, 8'(ch >> 1), 1'b0);
            push16(ch, 8'(8 + (ch >> 1)), 1'b1);
        end
        for (int r = 0; r < 16; r++) begin
            for (int t = 0; t < 2; t++) begin
                exp16(8'(r), 2 * (r % 8) + t, (r == 15) && (t == 1));
            end
        end
        found = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            #4;
            if (done16) begin
                found = 1'b1;
                break;
            end
        end
        check("F done seen", found, 1);
        check("F out_count", out_count16, 32);
        check("F beats", acc16_n, 32);
        check("F drained", exp16_q.size(), 0);
        check("F non-decreasing", mono_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
